game_controller: RTL and testbench

Sequencing controller for the 3x3 tic-tac-toe board. It accepts a cursor position and a place request from the player input logic, enforces move legality, and issues a one-cycle select to exactly one of the nine tile instances. It tracks whose turn it is, evaluates the board for a win or draw after every move, and clears the board for a new game.

---
 rtl/game_controller.sv | 116 +++++++++++
 tb/tb_game_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Tic-tac-toe sequencing controller: checks that each move is legal, issues a one-cycle tile select,
// scores the board for a win or draw after every move, and clears the board for a new game.
module game_controller #(
  parameter int         NUM_TILES = 9,
  parameter logic [1:0] EMPTY     = 2'b00,
  parameter logic [1:0] X_MARK    = 2'b01,
  parameter logic [1:0] O_MARK    = 2'b10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   place,
  input  logic                   new_game,
  input  logic [3:0]             cursor,
  input  logic [2*NUM_TILES-1:0] board,
  output logic [NUM_TILES-1:0]   sel,
  output logic                   turn,
  output logic                   tiles_clear,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic [7:0]             win_line,
  output logic [3:0]             move_count,
  output logic                   illegal_move
);

  typedef enum logic [2:0] {CLEAR, WAIT_MOVE, PLACE, CHECK, GAME_OVER} state_t;

  state_t     state;
  logic [1:0] mark;
  logic [7:0] line_hits;
  logic       cursor_free;

  // Lines are scored only for the side that just moved; the tile it marked is visible in CHECK.
  always_comb begin
    mark      = turn ? O_MARK : X_MARK;
    line_hits = '0;
    for (int r = 0; r < 3; r++) begin
      line_hits[r]   = (board[6*r +: 2] == mark) && (board[6*r+2 +: 2] == mark) &&
                       (board[6*r+4 +: 2] == mark);
      line_hits[3+r] = (board[2*r +: 2] == mark) && (board[2*(r+3) +: 2] == mark) &&
                       (board[2*(r+6) +: 2] == mark);
    end
    line_hits[6] = (board[1:0] == mark) && (board[9:8] == mark) && (board[17:16] == mark);
    line_hits[7] = (board[5:4] == mark) && (board[9:8] == mark) && (board[13:12] == mark);
  end

  // An off-board cursor matches no tile, so it can never be a free one.
  always_comb begin
    cursor_free = 1'b0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (cursor == 4'(i) && board[2*i +: 2] == EMPTY) cursor_free = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CLEAR;
      sel          <= '0;
      turn         <= 1'b0;
      tiles_clear  <= 1'b1;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      win_line     <= '0;
      move_count   <= '0;
      illegal_move <= 1'b0;
    end else begin
      sel          <= '0;
      illegal_move <= 1'b0;
      tiles_clear  <= 1'b0;
      if (new_game) begin
        state       <= CLEAR;
        tiles_clear <= 1'b1;
        turn        <= 1'b0;
        game_over   <= 1'b0;
        winner      <= 2'b00;
        win_line    <= '0;
        move_count  <= '0;
      end else begin
        case (state)
          CLEAR: state <= WAIT_MOVE;
          WAIT_MOVE: begin
            if (place) begin
              if (cursor_free) begin
                sel   <= NUM_TILES'(1) << cursor;
                state <= PLACE;
              end else begin
                illegal_move <= 1'b1;
              end
            end
          end
          PLACE: begin
            move_count <= move_count + 4'd1;
            state      <= CHECK;
          end
          CHECK: begin
            if (|line_hits) begin
              winner    <= mark;
              win_line  <= line_hits;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else if (move_count == 4'(NUM_TILES)) begin
              winner    <= 2'b11;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              turn  <= ~turn;
              state <= WAIT_MOVE;
            end
          end
          GAME_OVER: state <= GAME_OVER;
          default:   state <= CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: nine behavioural tiles close the loop, and a game-level model
// of cells, lines and turns predicts every controller output.
module tb_game_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        place = 1'b0;
  logic        new_game = 1'b0;
  logic [3:0]  cursor = '0;
  logic [17:0] board;
  logic [8:0]  sel;
  logic        turn;
  logic        tiles_clear;
  logic        game_over;
  logic [1:0]  winner;
  logic [7:0]  win_line;
  logic [3:0]  move_count;
  logic        illegal_move;

  logic [1:0]  tile_q [9];

  int checks = 0;
  int errors = 0;

  int m_cells [9];
  int m_turn, m_count, m_winner, m_over;
  logic [7:0] m_lines;
  int lines_tab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  game_controller dut (
    .clk(clk), .reset_n(reset_n), .place(place), .new_game(new_game), .cursor(cursor),
    .board(board), .sel(sel), .turn(turn), .tiles_clear(tiles_clear), .game_over(game_over),
    .winner(winner), .win_line(win_line), .move_count(move_count), .illegal_move(illegal_move)
  );

  always #5 clk = ~clk;

  // Tiles take the mover's mark on their select edge and clear on tiles_clear.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) tile_q[i] <= 2'b00;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (tiles_clear) tile_q[i] <= 2'b00;
        else if (sel[i] && tile_q[i] == 2'b00) tile_q[i] <= turn ? 2'b10 : 2'b01;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) board[2*i +: 2] = tile_q[i];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 9; i++) m_cells[i] = 0;
    m_turn = 0; m_count = 0; m_winner = 0; m_over = 0; m_lines = '0;
  endtask

  function automatic logic [7:0] modelLines(input int mark);
    logic [7:0] hits = '0;
    for (int l = 0; l < 8; l++)
      if (m_cells[lines_tab[l][0]] == mark && m_cells[lines_tab[l][1]] == mark &&
          m_cells[lines_tab[l][2]] == mark) hits[l] = 1'b1;
    return hits;
  endfunction

  task automatic checkGameState(input string tag);
    checkOutput({tag, "_turn"}, 32'(turn), 32'(m_turn));
    checkOutput({tag, "_count"}, 32'(move_count), 32'(m_count));
    checkOutput({tag, "_winner"}, 32'(winner), 32'(m_winner));
    checkOutput({tag, "_win_line"}, 32'(win_line), 32'(m_lines));
    checkOutput({tag, "_game_over"}, 32'(game_over), 32'(m_over));
  endtask

  // One place request, followed through to its outcome.
  task automatic applyStimulus(input int c);
    int   mark;
    logic legal;
    legal = 1'b0;
    if (!m_over && c <= 8) legal = (m_cells[c] == 0);
    mark = m_turn ? 2 : 1;
    @(negedge clk); place = 1'b1; cursor = 4'(c);
    @(negedge clk); place = 1'b0;
    if (m_over) begin
      checkOutput("over_sel", 32'(sel), 32'h0);
      checkOutput("over_illegal", 32'(illegal_move), 32'h0);
      checkGameState("over");
      return;
    end
    if (!legal) begin
      checkOutput("illegal_pulse", 32'(illegal_move), 32'h1);
      checkOutput("illegal_sel", 32'(sel), 32'h0);
      @(negedge clk);
      checkOutput("illegal_one_cycle", 32'(illegal_move), 32'h0);
      checkGameState("illegal");
      return;
    end
    checkOutput("sel_onehot", 32'(sel), 32'h1 << c);
    checkOutput("legal_no_illegal", 32'(illegal_move), 32'h0);
    checkOutput("place_turn", 32'(turn), 32'(m_turn));
    @(negedge clk);
    checkOutput("check_sel", 32'(sel), 32'h0);
    checkOutput("board_mark", 32'(board[2*c +: 2]), 32'(mark));
    m_cells[c] = mark;
    m_count++;
    m_lines = modelLines(mark);
    if (m_lines != 0) begin
      m_winner = mark; m_over = 1;
    end else if (m_count == 9) begin
      m_winner = 3; m_over = 1;
    end else begin
      m_turn = 1 - m_turn;
    end
    @(negedge clk);
    checkGameState("outcome");
  endtask

  task automatic restart(input logic with_place);
    @(negedge clk); new_game = 1'b1; place = with_place; cursor = 4'd4;
    @(negedge clk); new_game = 1'b0; place = 1'b0;
    checkOutput("restart_clear", 32'(tiles_clear), 32'h1);
    checkOutput("restart_sel", 32'(sel), 32'h0);
    checkOutput("restart_illegal", 32'(illegal_move), 32'h0);
    modelReset();
    @(negedge clk);
    checkOutput("restart_clear_done", 32'(tiles_clear), 32'h0);
    checkOutput("restart_board", 32'(board), 32'h0);
    checkGameState("restart");
  endtask

  task automatic playSequence(input int moves [$]);
    foreach (moves[k]) applyStimulus(moves[k]);
  endtask

  initial begin
    int c;
    modelReset();
    #1 reset_n = 1'b0;
    #12;
    checkOutput("rst_clear", 32'(tiles_clear), 32'h1);
    checkOutput("rst_sel", 32'(sel), 32'h0);
    checkOutput("rst_illegal", 32'(illegal_move), 32'h0);
    checkGameState("rst");
    @(negedge clk); reset_n = 1'b1;
    #1 checkOutput("first_clear_cycle", 32'(tiles_clear), 32'h1);
    @(negedge clk);
    checkOutput("idle_clear", 32'(tiles_clear), 32'h0);
    checkGameState("idle");

    playSequence('{0, 0, 12, 3, 1, 4, 2});
    checkOutput("toprow_winner", 32'(winner), 32'h1);
    checkOutput("toprow_line", 32'(win_line), 32'h01);
    applyStimulus(5);

    restart(1'b1);
    playSequence('{0, 1, 2, 4, 3, 5, 7, 6, 8});
    checkOutput("draw_winner", 32'(winner), 32'h3);
    applyStimulus(4);

    restart(1'b0);
    playSequence('{0, 2, 1, 4, 3, 6});
    checkOutput("antidiag_winner", 32'(winner), 32'h2);
    checkOutput("antidiag_line", 32'(win_line), 32'h80);

    restart(1'b0);
    @(negedge clk); place = 1'b1; cursor = 4'd4;
    @(negedge clk); place = 1'b0;
    checkOutput("pre_reset_sel", 32'(sel), 32'h010);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_sel_drop", 32'(sel), 32'h0);
    checkOutput("reset_tiles_clear", 32'(tiles_clear), 32'h1);
    modelReset();
    checkGameState("midmove_reset");
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_board", 32'(board), 32'h0);
    checkGameState("post_reset");

    for (int g = 0; g < 8; g++) begin
      restart(1'($urandom_range(0, 1)));
      for (int k = 0; k < 40 && !m_over; k++) begin
        if ($urandom_range(0, 9) == 0) c = $urandom_range(9, 15);
        else c = $urandom_range(0, 8);
        applyStimulus(c);
      end
      applyStimulus($urandom_range(0, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
